// File: rtl/moving_average_window.sv
// Multi-channel sliding-window averager: per-channel history of 2^LOG2_N samples,
// running sums and fill counts, with a floor or round-half-up mean one cycle after accept.
module moving_average_window #(
  parameter int unsigned DATA_W   = 5,
  parameter int unsigned LOG2_N   = 3,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ROUND    = 0,
  parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [CH_W-1:0]   o_ch,
  output logic [DATA_W-1:0] o_avg,
  output logic              o_full
);
  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned DEPTH = CHANNELS * N;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = DATA_W + LOG2_N;
  localparam int unsigned CNT_W = LOG2_N + 1;
  localparam int unsigned RND   = (ROUND != 0) ? (1 << (LOG2_N - 1)) : 0;

  typedef enum logic {StClear, StRun} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_clr_idx;
  logic [DATA_W-1:0] r_hist [DEPTH];
  logic [LOG2_N-1:0] r_ptr  [CHANNELS];
  logic [SUM_W-1:0]  r_sum  [CHANNELS];
  logic [CNT_W-1:0]  r_cnt  [CHANNELS];
  logic              r_valid;
  logic [CH_W-1:0]   r_ch;
  logic [DATA_W-1:0] r_avg;
  logic              r_full;

  logic              w_ch_ok;
  logic              w_accept;
  logic [CH_W-1:0]   w_ch;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [DATA_W-1:0] w_old;
  logic [SUM_W-1:0]  w_sum_new;
  logic [SUM_W-1:0]  w_rnd_sum;
  logic [CNT_W-1:0]  w_cnt_new;

  always_comb begin
    o_ready   = !rst && (r_state == StRun) && !i_flush;
    w_ch_ok   = 32'(i_ch) < CHANNELS;
    w_accept  = i_valid && o_ready && w_ch_ok;
    // Clamp so an out-of-range channel never indexes past the per-channel arrays.
    w_ch      = w_ch_ok ? i_ch : '0;
    w_wr_idx  = IDX_W'(32'(w_ch) * N + 32'(r_ptr[w_ch]));
    w_old     = r_hist[w_wr_idx];
    w_sum_new = r_sum[w_ch] - SUM_W'(w_old) + SUM_W'(i_data);
    // Max sum plus N/2 still fits in SUM_W bits, so no extra carry bit is needed.
    w_rnd_sum = w_sum_new + SUM_W'(RND);
    w_cnt_new = (r_cnt[w_ch] == CNT_W'(N)) ? r_cnt[w_ch] : r_cnt[w_ch] + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StClear;
      r_clr_idx <= '0;
      r_valid   <= 1'b0;
      r_ch      <= '0;
      r_avg     <= '0;
      r_full    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_ptr[c] <= '0;
        r_sum[c] <= '0;
        r_cnt[c] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        StClear: begin
          r_hist[r_clr_idx] <= '0;
          for (int c = 0; c < CHANNELS; c++) begin
            r_ptr[c] <= '0;
            r_sum[c] <= '0;
            r_cnt[c] <= '0;
          end
          if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
            r_state   <= StRun;
            r_clr_idx <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + IDX_W'(1);
          end
        end
        StRun: begin
          if (i_flush) begin
            r_state   <= StClear;
            r_clr_idx <= '0;
          end else if (w_accept) begin
            r_hist[w_wr_idx] <= i_data;
            r_ptr[w_ch]      <= r_ptr[w_ch] + LOG2_N'(1);
            r_sum[w_ch]      <= w_sum_new;
            r_cnt[w_ch]      <= w_cnt_new;
            r_valid          <= 1'b1;
            r_ch             <= i_ch;
            r_avg            <= DATA_W'(w_rnd_sum >> LOG2_N);
            r_full           <= (w_cnt_new == CNT_W'(N));
          end
        end
        default: r_state <= StClear;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_ch    = r_ch;
  assign o_avg   = r_avg;
  assign o_full  = r_full;

endmodule

// File: tb/tb_moving_average_window.sv
// Bench for moving_average_window: a 2-channel floor instance and a 3-channel rounding
// instance, checked every cycle against a window-of-samples model plus literal expectations.
module tb_moving_average_window;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_valid, a_flush, a_ready, a_ovalid, a_full;
  logic [0:0] a_ch, a_och;
  logic [4:0] a_data, a_avg;
  logic       b_rst, b_valid, b_flush, b_ready, b_ovalid, b_full;
  logic [1:0] b_ch, b_och;
  logic [4:0] b_data, b_avg;

  moving_average_window #(.DATA_W(5), .LOG2_N(3), .CHANNELS(2), .ROUND(0)) u_dut_a (
    .clk(clk), .rst(a_rst), .i_valid(a_valid), .i_ch(a_ch), .i_data(a_data),
    .o_ready(a_ready), .i_flush(a_flush), .o_valid(a_ovalid), .o_ch(a_och),
    .o_avg(a_avg), .o_full(a_full)
  );

  moving_average_window #(.DATA_W(5), .LOG2_N(3), .CHANNELS(3), .ROUND(1)) u_dut_b (
    .clk(clk), .rst(b_rst), .i_valid(b_valid), .i_ch(b_ch), .i_data(b_data),
    .o_ready(b_ready), .i_flush(b_flush), .o_valid(b_ovalid), .o_ch(b_och),
    .o_avg(b_avg), .o_full(b_full)
  );

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel's window is the last 8 accepted samples (zeros before fill).
  int   m_win [2][3][8];
  int   m_cnt [2][3];
  int   m_clear [2] = '{16, 24};
  logic m_valid [2] = '{1'b0, 1'b0};
  int   m_avg [2] = '{0, 0};
  int   m_ch [2] = '{0, 0};
  logic m_full [2] = '{1'b0, 1'b0};

  task automatic wipe(input int k);
    for (int c = 0; c < 3; c++) begin
      m_cnt[k][c] = 0;
      for (int j = 0; j < 8; j++) m_win[k][c][j] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic r, input logic v, input int ch,
                            input int d, input logic f);
    int nch;
    int s;
    nch = (k == 0) ? 2 : 3;
    if (r) begin
      m_clear[k] = nch * 8;
      wipe(k);
      m_valid[k] = 1'b0;
      m_avg[k] = 0;
      m_ch[k] = 0;
      m_full[k] = 1'b0;
    end else begin
      m_valid[k] = 1'b0;
      if (m_clear[k] > 0) begin
        m_clear[k]--;
      end else if (f) begin
        m_clear[k] = nch * 8;
        wipe(k);
      end else if (v && ch < nch) begin
        for (int j = 7; j > 0; j--) m_win[k][ch][j] = m_win[k][ch][j-1];
        m_win[k][ch][0] = d;
        if (m_cnt[k][ch] < 8) m_cnt[k][ch]++;
        s = 0;
        for (int j = 0; j < 8; j++) s += m_win[k][ch][j];
        m_avg[k] = (s + ((k == 1) ? 4 : 0)) / 8;
        m_ch[k] = ch;
        m_full[k] = (m_cnt[k][ch] == 8);
        m_valid[k] = 1'b1;
      end
    end
  endtask

  initial wipe(0);
  initial wipe(1);

  always @(posedge clk) begin
    model_step(0, a_rst, a_valid, int'(a_ch), int'(a_data), a_flush);
    model_step(1, b_rst, b_valid, int'(b_ch), int'(b_data), b_flush);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_ready", a_ready, !a_rst && m_clear[0] == 0 && !a_flush);
      check("a_valid", a_ovalid, m_valid[0]);
      check("a_avg", a_avg, m_avg[0]);
      check("a_ch", a_och, m_ch[0]);
      check("a_full", a_full, m_full[0]);
      check("b_ready", b_ready, !b_rst && m_clear[1] == 0 && !b_flush);
      check("b_valid", b_ovalid, m_valid[1]);
      check("b_avg", b_avg, m_avg[1]);
      check("b_ch", b_och, m_ch[1]);
      check("b_full", b_full, m_full[1]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  int fill_lit [8] = '{3, 7, 11, 15, 19, 23, 27, 31};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int na, nb;
    a_rst = 1'b1; a_valid = 1'b0; a_flush = 1'b0; a_ch = '0; a_data = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_flush = 1'b0; b_ch = '0; b_data = '0;
    step();
    chk_en = 1'b1;
    step();
    a_rst = 1'b0;
    b_rst = 1'b0;
    check("rst_avg", a_avg, 0);
    check("rst_valid", a_ovalid, 0);
    check("rst_full", b_full, 0);

    // Ready stays low for exactly CHANNELS*N cycles after reset release.
    na = 0; nb = 0;
    for (int i = 0; i < 100; i++) begin
      if (!a_ready) na++;
      if (!b_ready) nb++;
      if (a_ready && b_ready) break;
      step();
    end
    check("rst_sweep_a", na, 16);
    check("rst_sweep_b", nb, 24);

    // Fill ch0 with 31 back-to-back, then one 0.
    for (int i = 0; i < 9; i++) begin
      a_valid = 1'b1; a_ch = 1'b0; a_data = (i < 8) ? 5'd31 : 5'd0;
      step();
      check("fill_avg", a_avg, (i < 8) ? fill_lit[i] : 27);
      check("fill_full", a_full, i >= 7);
    end
    a_valid = 1'b0;

    // Rounding instance: 4 -> 1, then eight 31s -> 31.
    b_valid = 1'b1; b_ch = 2'd0; b_data = 5'd4;
    step();
    check("round_4", b_avg, 1);
    for (int i = 0; i < 8; i++) begin
      b_data = 5'd31;
      step();
    end
    check("round_31", b_avg, 31);
    check("round_full", b_full, 1);
    b_ch = 2'd3; b_data = 5'd31;
    step();
    check("illegal_ch_valid", b_ovalid, 0);
    b_ch = 2'd1; b_data = 5'd8;
    step();
    check("after_illegal_avg", b_avg, 1);
    check("after_illegal_ch", b_och, 1);
    check("after_illegal_full", b_full, 0);
    b_valid = 1'b0;

    // Reset in cycle 5 of the sweep restarts a full sweep.
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    repeat (4) step();
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    nb = 0;
    for (int i = 0; i < 100 && !b_ready; i++) begin
      nb++;
      step();
    end
    check("midclear_sweep_b", nb, 24);

    // Flush with a coincident sample: sample dropped, 16-cycle sweep.
    for (int i = 0; i < 8; i++) begin
      a_valid = 1'b1; a_ch = 1'b0; a_data = 5'd31;
      step();
    end
    check("prefill_avg", a_avg, 31);
    a_flush = 1'b1; a_data = 5'd5;
    #1;
    check("flush_ready", a_ready, 0);
    step();
    a_flush = 1'b0; a_valid = 1'b0;
    na = 0;
    for (int i = 0; i < 100 && !a_ready; i++) begin
      na++;
      step();
    end
    check("flush_sweep_a", na, 16);
    a_valid = 1'b1; a_data = 5'd8;
    step();
    check("post_flush_avg", a_avg, 1);
    check("post_flush_full", a_full, 0);
    a_valid = 1'b0;

    // Clean both channels, then interleave ch0=31 and ch1=8.
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    for (int i = 0; i < 100 && !a_ready; i++) step();
    check("reflush_ready", a_ready, 1);
    for (int i = 0; i < 16; i++) begin
      a_valid = 1'b1; a_ch = 1'(i % 2); a_data = (i % 2 == 0) ? 5'd31 : 5'd8;
      step();
      check("indep_avg", a_avg, (i % 2 == 0) ? fill_lit[i/2] : i/2 + 1);
      check("indep_ch", a_och, i % 2);
    end
    a_valid = 1'b0;

    // Random traffic with occasional flushes on both instances.
    for (int i = 0; i < 3000; i++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      a_ch = 1'($urandom);
      a_data = 5'($urandom);
      a_flush = ($urandom_range(0, 199) == 0);
      b_valid = ($urandom_range(0, 3) != 0);
      b_ch = 2'($urandom);
      b_data = 5'($urandom);
      b_flush = ($urandom_range(0, 199) == 0);
      step();
    end
    a_valid = 1'b0; a_flush = 1'b0;
    b_valid = 1'b0; b_flush = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/moving_average_window.md
# moving_average_window

Multi-channel, parametrised sliding-window averager for the rolling-average datapath. It keeps a true per-channel history of the last 2^LOG2_N samples, so the element leaving the window is read internally rather than supplied by the caller. It maintains a running sum per channel and emits a floor or rounded mean one cycle after each accepted sample. It sits between the sample source (valid/ready) and downstream consumers, time-multiplexing up to CHANNELS independent streams.

## Interface
- DATA_W, 5: sample and average width (unsigned).
- LOG2_N, 3: window depth N = 2^LOG2_N samples per channel, LOG2_N >= 1.
- CHANNELS, 2: number of independent channels, >= 1.
- ROUND, 0: 0 = floor mean, 1 = round-half-up mean.
- CH_W, max(1, clog2(CHANNELS)): channel index width (derived).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  sample present.
- i_ch  in  CH_W  channel of presented sample.
- i_data  in  DATA_W  sample value.
- o_ready  out  1  block can accept; combinational: (state==RUN) && !i_flush.
- i_flush  in  1  zero all history, sums, and fill counts.
- o_valid  out  1  one-cycle pulse, result available.
- o_ch  out  CH_W  channel of result.
- o_avg  out  DATA_W  window mean.
- o_full  out  1  channel's window fully populated (N samples since last clear).

## Operation
- Storage: history array of CHANNELS*N DATA_W-bit entries, addressed {ch, wr_ptr[ch]}. Per channel: wr_ptr (LOG2_N bits, wraps N-1 -> 0), sum (DATA_W+LOG2_N bits), fill count (saturates at N).
- FSM states:
  - CLEAR: sweeps one history entry per cycle to 0, also zeroing all sums, pointers and counts. o_ready=0. Goes to RUN after the last entry (CHANNELS*N cycles).
  - RUN: accepts samples.
  - Entry into CLEAR: rst, or i_flush sampled high in RUN.
- Accept: i_valid && o_ready && i_ch < CHANNELS. On that edge:
  - old = hist[ch][wr_ptr]; hist[ch][wr_ptr] <= i_data; wr_ptr++.
  - sum_new = sum - old + i_data; count = min(count+1, N).
  - o_avg <= (sum_new + (ROUND ? 2^(LOG2_N-1) : 0)) >> LOG2_N. This never overflows: (2^DATA_W-1)*N + N/2 < 2^DATA_W*N.
  - o_ch <= i_ch; o_full <= (count_new == N); o_valid <= 1.
- Out-of-range i_ch (>= CHANNELS) with i_valid && o_ready: sample dropped, no state change, o_valid stays 0.
- Before a window is full, missing samples count as 0. o_avg is sum/N, not sum/count.
- i_flush with i_valid in the same cycle: o_ready=0, so the sample is not accepted.
- i_flush during CLEAR: ignored; the sweep continues.
- Channels are fully independent; interleaving in any order, including back-to-back same-channel, is legal.

## Timing
- Reset values: o_valid=0, o_avg=0, o_ch=0, o_full=0; state=CLEAR. o_ready=0 while rst is high.
- After rst deasserts, o_ready rises after exactly CHANNELS*N clock edges.
- rst mid-CLEAR or mid-RUN restarts the sweep from entry 0.
- Flush: i_flush sampled at edge k forces o_ready=0 from cycle k+1 for CHANNELS*N cycles. o_valid pulses already in flight still complete.
- Latency: sample accepted at edge k produces o_valid high during cycle k+1, with o_avg including that sample.
- Throughput: one sample per cycle in RUN.
- o_avg, o_ch and o_full hold their values between pulses.

## Test plan
Defaults unless stated: DATA_W=5, LOG2_N=3, CHANNELS=2, ROUND=0.
- Reset: rst 2 cycles, then low -> o_ready low for exactly 16 cycles, then high; all outputs 0.
- Fill and full flag: ch0 fed 31 eight times back-to-back -> o_avg 3,7,11,15,19,23,27,31; o_full=1 only on the 8th; a 9th sample of 0 -> o_avg 27 with o_full still 1.
- Channel independence: alternate ch0=31, ch1=8 for 16 accepts -> ch0 follows the fill sequence above; ch1 follows 1,2,...,8; neither channel perturbs the other.
- Rounding (ROUND=1): single sample 4 on ch0 -> o_avg 1 (floor mode gives 0); eight samples of 31 -> 31, with no overflow.
- Flush: ch0 filled with 31, assert i_flush together with i_valid carrying 5 -> sample not accepted, o_ready low 16 cycles; next sample 8 -> o_avg 1, o_full 0.
- Illegal channel and mid-clear reset: CHANNELS=3, i_ch=3 -> no o_valid and no state change. rst asserted in cycle 5 of CLEAR -> a full 24-cycle sweep restarts.
